mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback steps over 3-5 cycles. Drives the shared ALU's 2-bit aluop into the existing ALU decoder, plus all mux selects and write enables. Sits beside the ALU decoder in the controller; the datapath supplies op and the ALU zero flag.

---
 rtl/mips_ctrl_pkg.sv | 59 +++++
 rtl/mc_ctrl_outdec.sv | 78 +++++++
 rtl/mips_multicycle_ctrl.sv | 89 ++++++++
 tb/tb_mips_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control word produced per state; pcwrite/branch are folded into pcen at the top.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       instr_done;
  } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure state -> control-word decode for the multicycle controller.
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t ctrl
);

  // Moore decode; every field defaults to 0 and only the listed ones are raised.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg   = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca    = 1'b1;
        ctrl.alusrcb    = SRCB_RT;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JEX: begin
        ctrl.pcsrc      = PCSRC_JUMP;
        ctrl.pcwrite    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit SUPPORT_ADDI = 1'b1,
  parameter bit SUPPORT_J    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t     state_q;
  ctrl_word_t cw;
  ctrl_word_t cw_g;
  logic       op_addi;
  logic       op_j;

  // Optional opcodes collapse to "unsupported" when their parameter is cleared.
  always_comb begin
    op_addi = SUPPORT_ADDI && (op == OP_ADDI);
    op_j    = SUPPORT_J && (op == OP_J);
  end

  // State register with synchronous reset and next-state selection.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          if ((op == OP_LW) || (op == OP_SW)) state_q <= S_MEMADR;
          else if (op == OP_RTYPE)            state_q <= S_RTYPEEX;
          else if (op == OP_BEQ)              state_q <= S_BEQEX;
          else if (op_addi)                   state_q <= S_ADDIEX;
          else if (op_j)                      state_q <= S_JEX;
          else                                state_q <= S_FETCH;
        end
        S_MEMADR:  state_q <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   state_q <= S_MEMWB;
        S_RTYPEEX: state_q <= S_RTYPEWB;
        S_ADDIEX:  state_q <= S_ADDIWB;
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  mc_ctrl_outdec u_outdec (
    .state (state_q),
    .ctrl  (cw)
  );

  // Reset holds every enable and select low, even before the first reset edge lands.
  always_comb cw_g = reset ? '0 : cw;

  assign iord       = cw_g.iord;
  assign memwrite   = cw_g.memwrite;
  assign irwrite    = cw_g.irwrite;
  assign regdst     = cw_g.regdst;
  assign memtoreg   = cw_g.memtoreg;
  assign regwrite   = cw_g.regwrite;
  assign alusrca    = cw_g.alusrca;
  assign alusrcb    = cw_g.alusrcb;
  assign aluop      = cw_g.aluop;
  assign pcsrc      = cw_g.pcsrc;
  assign instr_done = cw_g.instr_done;
  assign pcen       = cw_g.pcwrite | (cw_g.branch & zero);
  assign illegal_op = ~reset & (state_q == S_DECODE) &
                      ~((op == OP_LW) | (op == OP_SW) | (op == OP_RTYPE) |
                        (op == OP_BEQ) | op_addi | op_j);
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: vector table plus scoreboard queue.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;

  logic a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite, a_alusrca;
  logic [1:0] a_alusrcb, a_aluop, a_pcsrc;
  logic a_pcen, a_done, a_ill;
  logic [3:0] a_state;

  logic b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca;
  logic [1:0] b_alusrcb, b_aluop, b_pcsrc;
  logic b_pcen, b_done, b_ill;
  logic [3:0] b_state;

  logic [15:0] a_ctl, b_ctl;
  assign a_ctl = {a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite, a_alusrca,
                  a_alusrcb, a_aluop, a_pcsrc, a_pcen, a_done, a_ill};
  assign b_ctl = {b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca,
                  b_alusrcb, b_aluop, b_pcsrc, b_pcen, b_done, b_ill};

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.SUPPORT_ADDI(1'b1), .SUPPORT_J(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .iord(a_iord), .memwrite(a_memwrite), .irwrite(a_irwrite), .regdst(a_regdst),
    .memtoreg(a_memtoreg), .regwrite(a_regwrite), .alusrca(a_alusrca), .alusrcb(a_alusrcb),
    .aluop(a_aluop), .pcsrc(a_pcsrc), .pcen(a_pcen), .instr_done(a_done),
    .illegal_op(a_ill), .state(a_state)
  );

  mips_multicycle_ctrl #(.SUPPORT_ADDI(1'b1), .SUPPORT_J(1'b0)) dut_noj (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite), .regdst(b_regdst),
    .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca), .alusrcb(b_alusrcb),
    .aluop(b_aluop), .pcsrc(b_pcsrc), .pcen(b_pcen), .instr_done(b_done),
    .illegal_op(b_ill), .state(b_state)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic        zero;
    logic        ill;
    logic [2:0]  ncyc;
    logic [19:0] seq;   // state per cycle, first cycle in the top nibble
  } vec_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
  } exp_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];
  exp_t sbq [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Expected outputs per state, taken straight from the state/output table.
  function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic ill, input logic z);
    logic iord_e = 0, mw_e = 0, irw_e = 0, rd_e = 0, m2r_e = 0, rw_e = 0, sa_e = 0;
    logic [1:0] sb_e = 2'b00, ao_e = 2'b00, ps_e = 2'b00;
    logic pcen_e = 0, done_e = 0, ill_e = 0;
    case (st)
      4'd0:  begin irw_e = 1; sb_e = 2'b01; pcen_e = 1; end
      4'd1:  begin sb_e = 2'b11; ill_e = ill; end
      4'd2:  begin sa_e = 1; sb_e = 2'b10; end
      4'd3:  begin iord_e = 1; end
      4'd4:  begin m2r_e = 1; rw_e = 1; done_e = 1; end
      4'd5:  begin iord_e = 1; mw_e = 1; done_e = 1; end
      4'd6:  begin sa_e = 1; ao_e = 2'b10; end
      4'd7:  begin rd_e = 1; rw_e = 1; done_e = 1; end
      4'd8:  begin sa_e = 1; ao_e = 2'b01; ps_e = 2'b01; pcen_e = z; done_e = 1; end
      4'd9:  begin sa_e = 1; sb_e = 2'b10; end
      4'd10: begin rw_e = 1; done_e = 1; end
      4'd11: begin ps_e = 2'b10; pcen_e = 1; done_e = 1; end
      default: ;
    endcase
    return {iord_e, mw_e, irw_e, rd_e, m2r_e, rw_e, sa_e, sb_e, ao_e, ps_e, pcen_e, done_e, ill_e};
  endfunction

  task automatic push_exp(input logic [3:0] st, input logic ill, input logic z);
    exp_t e;
    e.st  = st;
    e.ctl = exp_ctl(st, ill, z);
    sbq.push_back(e);
  endtask

  // Pop one expectation and compare state plus control word of the chosen instance.
  task automatic check_dut(input string name, input logic [3:0] st, input logic [15:0] ctl);
    exp_t e;
    n_tests += 2;
    if (sbq.size() == 0) begin
      n_fail += 2;
      $display("FAIL %s: scoreboard empty, got state=%0d ctl=%h", name, st, ctl);
    end else begin
      e = sbq.pop_front();
      if (st !== e.st) begin
        n_fail++;
        $display("FAIL %s state: got %0d expected %0d", name, st, e.st);
      end
      if (ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl: got %h expected %h", name, ctl, e.ctl);
      end
    end
  endtask

  task automatic check_zero(input string name, input logic [15:0] ctl);
    n_tests++;
    if (ctl !== 16'h0000) begin
      n_fail++;
      $display("FAIL %s: got ctl=%h expected 0000", name, ctl);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{op: OP_LW,     zero: 1'b0, ill: 1'b0, ncyc: 3'd5, seq: 20'h01234};
    vecs[1] = '{op: OP_SW,     zero: 1'b0, ill: 1'b0, ncyc: 3'd4, seq: 20'h01250};
    vecs[2] = '{op: OP_RTYPE,  zero: 1'b0, ill: 1'b0, ncyc: 3'd4, seq: 20'h01670};
    vecs[3] = '{op: OP_BEQ,    zero: 1'b1, ill: 1'b0, ncyc: 3'd3, seq: 20'h01800};
    vecs[4] = '{op: OP_BEQ,    zero: 1'b0, ill: 1'b0, ncyc: 3'd3, seq: 20'h01800};
    vecs[5] = '{op: OP_ADDI,   zero: 1'b0, ill: 1'b0, ncyc: 3'd4, seq: 20'h019A0};
    vecs[6] = '{op: OP_J,      zero: 1'b0, ill: 1'b0, ncyc: 3'd3, seq: 20'h01B00};
    vecs[7] = '{op: 6'b111111, zero: 1'b0, ill: 1'b1, ncyc: 3'd2, seq: 20'h01000};
    vecs[8] = '{op: 6'b000011, zero: 1'b1, ill: 1'b1, ncyc: 3'd2, seq: 20'h01000};

    reset = 1'b1;
    op    = 6'b000000;
    zero  = 1'b0;
    tick();
    tick();
    check_zero("reset_hold", a_ctl);
    check_zero("reset_hold_noj", b_ctl);
    reset = 1'b0;

    // Back-to-back instructions from the table; first cycle right after reset release.
    for (int v = 0; v < NVEC; v++) begin
      op   = vecs[v].op;
      zero = vecs[v].zero;
      #1;
      for (int i = 0; i < int'(vecs[v].ncyc); i++) begin
        if (i > 0) tick();
        push_exp(vecs[v].seq[4*(4-i) +: 4], vecs[v].ill, vecs[v].zero);
        check_dut($sformatf("vec%0d_c%0d", v, i), a_state, a_ctl);
      end
      tick();
    end

    // beq with zero flipped inside BEQEX: pcen follows zero combinationally.
    do_reset(2);
    op = OP_BEQ; zero = 1'b0;
    push_exp(4'd0, 1'b0, 1'b0); check_dut("beqflip_fetch", a_state, a_ctl);
    tick();
    push_exp(4'd1, 1'b0, 1'b0); check_dut("beqflip_decode", a_state, a_ctl);
    tick();
    push_exp(4'd8, 1'b0, 1'b0); check_dut("beqflip_nt", a_state, a_ctl);
    zero = 1'b1;
    #1;
    push_exp(4'd8, 1'b0, 1'b1); check_dut("beqflip_t", a_state, a_ctl);
    tick();
    push_exp(4'd0, 1'b0, 1'b1); check_dut("beqflip_next", a_state, a_ctl);

    // Reset during MEMRD of lw aborts before MEMWB can write the register file.
    do_reset(1);
    op = OP_LW; zero = 1'b0;
    push_exp(4'd0, 1'b0, 1'b0); check_dut("abort_fetch", a_state, a_ctl);
    tick();
    push_exp(4'd1, 1'b0, 1'b0); check_dut("abort_decode", a_state, a_ctl);
    tick();
    push_exp(4'd2, 1'b0, 1'b0); check_dut("abort_memadr", a_state, a_ctl);
    tick();
    push_exp(4'd3, 1'b0, 1'b0); check_dut("abort_memrd", a_state, a_ctl);
    reset = 1'b1;
    #1;
    check_zero("abort_forced", a_ctl);
    tick();
    check_zero("abort_rst1", a_ctl);
    tick();
    check_zero("abort_rst2", a_ctl);
    reset = 1'b0;
    #1;
    push_exp(4'd0, 1'b0, 1'b0); check_dut("abort_release", a_state, a_ctl);

    // j is illegal on the SUPPORT_J=0 instance but runs JEX on the full one.
    do_reset(2);
    op = OP_J; zero = 1'b0;
    push_exp(4'd0, 1'b0, 1'b0); check_dut("j_fetch", a_state, a_ctl);
    push_exp(4'd0, 1'b0, 1'b0); check_dut("noj_fetch", b_state, b_ctl);
    tick();
    push_exp(4'd1, 1'b0, 1'b0); check_dut("j_decode", a_state, a_ctl);
    push_exp(4'd1, 1'b1, 1'b0); check_dut("noj_decode", b_state, b_ctl);
    tick();
    push_exp(4'd11, 1'b0, 1'b0); check_dut("j_jex", a_state, a_ctl);
    push_exp(4'd0, 1'b0, 1'b0);  check_dut("noj_back", b_state, b_ctl);

    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d leftover entries expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
